soc_loader: RTL and testbench

- Host-side initiator for the SoC user memory port (address, write data, write enable, read data).
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive SoC memory locations while holding the CPU in reset and halt.
- After the writes settle, reads the image back and checks it against a running checksum.
- Releases the CPU on a match; latches an error and keeps the CPU held on a mismatch.

---
 rtl/soc_pkg.sv | 18 +
 rtl/loader_cksum.sv | 24 ++
 rtl/soc_loader.sv | 136 +++++++++++++
 tb/tb_soc_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// Shared types and sizes for the SoC image loader.
// Imported by the loader top and its checksum accumulator.
package soc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        VERIFY,
        DONE,
        ERROR
    } state_t;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;

endpackage

// File: rtl/loader_cksum.sv
// 8-bit wrapping additive checksum with synchronous clear.
// Clear wins over add when both are requested.
module loader_cksum
    import soc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/soc_loader.sv
// Streams a byte image into SoC memory with the CPU held, reads it
// back, and releases the CPU only when the read-back sum matches.
module soc_loader
    import soc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 8'h00,
    parameter int                SETTLE_CYCLES = 16,
    parameter bit                AUTO_RUN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_we,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              soc_rst,
    output logic              soc_hlt,
    output logic [8:0]        count,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);

    state_t            state;
    logic [TW-1:0]     tmr;
    logic [8:0]        idx;
    logic [DATA_W-1:0] wsum;
    logic [DATA_W-1:0] rsum;
    logic              acc;
    logic              sess;
    logic              rd_en;

    assign acc   = (state == LOAD) && s_valid && s_ready;
    assign sess  = start && (state == IDLE || state == DONE
                             || state == ERROR);
    assign rd_en = (state == VERIFY) && (idx != count);

    loader_cksum u_wsum (
        .clk (clk),
        .rst (rst),
        .clr (sess),
        .en  (acc),
        .din (s_data),
        .sum (wsum)
    );

    loader_cksum u_rsum (
        .clk (clk),
        .rst (rst),
        .clr (sess),
        .en  (rd_en),
        .din (m_rdata),
        .sum (rsum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tmr     <= '0;
            idx     <= '0;
            s_ready <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= BASE_ADDR;
            m_data  <= '0;
            soc_rst <= 1'b1;
            soc_hlt <= 1'b1;
            count   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            m_we <= 1'b0;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        count   <= '0;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        soc_rst <= 1'b1;
                        soc_hlt <= 1'b1;
                    end
                end
                LOAD: begin
                    if (acc) begin
                        m_we   <= 1'b1;
                        m_addr <= BASE_ADDR + count[ADDR_W-1:0];
                        m_data <= s_data;
                        count  <= count + 9'd1;
                        // 256th beat fills memory, so it ends the image too
                        if (s_last || count == 9'(MEM_DEPTH - 1)) begin
                            s_ready <= 1'b0;
                            state   <= SETTLE;
                            tmr     <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr == TW'(SETTLE_CYCLES - 1)) begin
                        state  <= VERIFY;
                        m_addr <= BASE_ADDR;
                        idx    <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                VERIFY: begin
                    if (idx == count) begin
                        if (rsum == wsum) begin
                            state <= DONE;
                            done  <= 1'b1;
                            if (AUTO_RUN) begin
                                soc_rst <= 1'b0;
                                soc_hlt <= 1'b0;
                            end
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end else begin
                        idx    <= idx + 9'd1;
                        m_addr <= m_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_loader.sv
// Directed bench for soc_loader: two instances, base 00 and base FE,
// each backed by a 256-byte memory model.
module tb_soc_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       corrupt;

    logic       start_a, sv_a, sl_a, srdy_a, we_a, srst_a, shlt_a;
    logic       done_a, err_a;
    logic [7:0] sd_a, addr_a, wd_a, rd_a;
    logic [8:0] cnt_a;

    logic       start_b, sv_b, sl_b, srdy_b, we_b, srst_b, shlt_b;
    logic       done_b, err_b;
    logic [7:0] sd_b, addr_b, wd_b, rd_b;
    logic [8:0] cnt_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] wa_q[$], wd_q[$], wba_q[$], wbd_q[$], exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    soc_loader #(.BASE_ADDR(8'h00)) u_a (
        .clk(clk), .rst(rst), .start(start_a),
        .s_valid(sv_a), .s_data(sd_a), .s_last(sl_a),
        .s_ready(srdy_a), .m_addr(addr_a), .m_data(wd_a),
        .m_we(we_a), .m_rdata(rd_a), .soc_rst(srst_a),
        .soc_hlt(shlt_a), .count(cnt_a), .done(done_a),
        .err(err_a)
    );

    soc_loader #(.BASE_ADDR(8'hFE)) u_b (
        .clk(clk), .rst(rst), .start(start_b),
        .s_valid(sv_b), .s_data(sd_b), .s_last(sl_b),
        .s_ready(srdy_b), .m_addr(addr_b), .m_data(wd_b),
        .m_we(we_b), .m_rdata(rd_b), .soc_rst(srst_b),
        .soc_hlt(shlt_b), .count(cnt_b), .done(done_b),
        .err(err_b)
    );

    assign rd_a = (corrupt && addr_a == 8'd2) ? 8'h00 : mem_a[addr_a];
    assign rd_b = mem_b[addr_b];

    always @(posedge clk) begin
        if (we_a) begin
            mem_a[addr_a] <= wd_a;
            wa_q.push_back(addr_a);
            wd_q.push_back(wd_a);
        end
        if (we_b) begin
            mem_b[addr_b] <= wd_b;
            wba_q.push_back(addr_b);
            wbd_q.push_back(wd_b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        sv_a = 1'b1;
        sd_a = d;
        sl_a = l;
        @(negedge clk);
        sv_a = 1'b0;
        sl_a = 1'b0;
    endtask

    task automatic pulse_start();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_verdict(output int n);
        n = 0;
        while (!(done_a || err_a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("verdict_in_time", 32'(n < 1000), 1);
    endtask

    task automatic check_writes(input string tag, input logic [7:0] base);
        chk({tag, "_nwrites"}, wa_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < wa_q.size()) begin
                chk({tag, "_addr"}, wa_q[i], 8'(base + i));
                chk({tag, "_data"}, wd_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        foreach (mem_a[i]) mem_a[i] = 8'h00;
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        rst = 1'b0;
        corrupt = 1'b0;
        {start_a, sv_a, sl_a, start_b, sv_b, sl_b} = '0;
        sd_a = 8'h00;
        sd_b = 8'h00;
        repeat (2) @(negedge clk);

        chk("rst_s_ready", srdy_a, 0);
        chk("rst_m_we", we_a, 0);
        chk("rst_m_addr_a", addr_a, 8'h00);
        chk("rst_m_addr_b", addr_b, 8'hFE);
        chk("rst_m_data", wd_a, 0);
        chk("rst_soc_rst", srst_a, 1);
        chk("rst_soc_hlt", shlt_a, 1);
        chk("rst_count", cnt_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        rst = 1'b1;
        @(negedge clk);

        // happy path; the beat presented with start must be dropped
        sv_a = 1'b1;
        sd_a = 8'hEE;
        pulse_start();
        sv_a = 1'b0;
        chk("start_ready", srdy_a, 1);
        chk("start_no_write", wa_q.size(), 0);
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        send(8'h44, 1);
        chk("last_we", we_a, 1);
        chk("last_addr", addr_a, 8'h03);
        chk("last_ready", srdy_a, 0);
        chk("last_count", cnt_a, 4);
        wait_verdict(lat);
        chk("latency", lat, 21);
        chk("happy_done", done_a, 1);
        chk("happy_err", err_a, 0);
        chk("happy_soc_rst", srst_a, 0);
        chk("happy_soc_hlt", shlt_a, 0);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_writes("happy", 8'h00);

        // reload from DONE
        wa_q.delete();
        wd_q.delete();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        chk("reload_soc_rst", srst_a, 1);
        chk("reload_soc_hlt", shlt_a, 1);
        chk("reload_count", cnt_a, 0);
        chk("reload_done", done_a, 0);
        chk("reload_ready", srdy_a, 1);
        @(negedge clk);
        start_a = 1'b0;
        send(8'hAA, 0);
        send(8'h55, 1);
        wait_verdict(lat);
        chk("reload_pass", done_a, 1);
        chk("reload_cnt2", cnt_a, 2);
        exp_q = '{8'hAA, 8'h55};
        check_writes("reload", 8'h00);

        // valid gaps
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        begin
            bit pat [6] = '{1, 0, 1, 1, 0, 1};
            int k = 0;
            foreach (pat[i]) begin
                if (pat[i]) begin
                    send(8'(k + 1), k == 3);
                    k++;
                end else begin
                    @(negedge clk);
                end
            end
        end
        wait_verdict(lat);
        chk("gaps_done", done_a, 1);
        chk("gaps_count", cnt_a, 4);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_writes("gaps", 8'h00);

        // corrupted read at address 2
        pulse_start();
        corrupt = 1'b1;
        send(8'h10, 0);
        send(8'h20, 0);
        send(8'h30, 0);
        send(8'h40, 0);
        send(8'h50, 1);
        wait_verdict(lat);
        chk("bad_err", err_a, 1);
        chk("bad_done", done_a, 0);
        chk("bad_soc_rst", srst_a, 1);
        chk("bad_soc_hlt", shlt_a, 1);
        corrupt = 1'b0;

        // asynchronous reset in the middle of a load
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        send(8'hA1, 0);
        send(8'hA2, 0);
        send(8'hA3, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_m_we", we_a, 0);
        chk("arst_m_addr", addr_a, 8'h00);
        chk("arst_m_data", wd_a, 0);
        chk("arst_ready", srdy_a, 0);
        chk("arst_count", cnt_a, 0);
        chk("arst_soc_rst", srst_a, 1);
        chk("arst_soc_hlt", shlt_a, 1);
        chk("arst_err", err_a, 0);
        @(negedge clk);
        rst = 1'b1;
        sv_a = 1'b1;
        sd_a = 8'hFF;
        repeat (3) @(negedge clk);
        sv_a = 1'b0;
        chk("arst_idle_ready", srdy_a, 0);
        chk("arst_idle_count", cnt_a, 0);
        chk("arst_nwrites", wa_q.size(), 2);

        // full 256-byte image from base FE
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        sv_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sd_b = 8'(i) ^ 8'h5A;
            @(negedge clk);
        end
        chk("wrap_ready", srdy_b, 0);
        chk("wrap_count", cnt_b, 256);
        chk("wrap_last_addr", addr_b, 8'hFD);
        sd_b = 8'hC3;
        repeat (2) @(negedge clk);
        sv_b = 1'b0;
        chk("wrap_nwrites", wba_q.size(), 256);
        for (int i = 0; i < 256 && i < wba_q.size(); i++) begin
            chk("wrap_addr", wba_q[i], 8'(8'hFE + i));
            chk("wrap_data", wbd_q[i], 8'(i) ^ 8'h5A);
        end
        lat = 0;
        while (!(done_b || err_b) && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        chk("wrap_done", done_b, 1);
        chk("wrap_err", err_b, 0);
        chk("wrap_soc_rst", srst_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
